fft_pair_align: RTL

- Sits between the two channel FFT cores (X and Y paths) and the cal block.
- Each FFT core emits its bin stream independently, so the two streams can be skewed by up to FIFO_DEPTH cycles.
- This block buffers each stream in its own small FIFO and releases bins in matched pairs, together with fft_out_valid, a bin index and a frame-end marker.
- It flags overflow and frame-boundary mismatches so the cal result can be discarded.

---
 rtl/fft_cal_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/fft_pair_align.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fft_cal_pkg.sv
// Shared definitions for the FFT-to-cal datapath: sizes and the packed bin word
// that travels through the per-channel alignment FIFOs.
package fft_cal_pkg;

    localparam int DW         = 24;
    localparam int NFFT       = 2048;
    localparam int BIN_W      = 11;
    localparam int FIFO_DEPTH = 16;
    localparam int WORD_W     = 2 * DW + 1;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          last;
    } bin_word_t;

    function automatic bin_word_t make_word(input logic [DW-1:0] re,
                                            input logic [DW-1:0] im,
                                            input logic          last);
        bin_word_t w;
        w.re   = re;
        w.im   = im;
        w.last = last;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. dout always presents the oldest entry; the caller
// must only assert rd_en when the FIFO is not empty.
module sync_fifo #(
    parameter int W     = 49,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  din,
    input  logic          rd_en,
    output logic [W-1:0]  dout,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_wr;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A simultaneous read frees the slot, so a full FIFO still accepts the write.
    assign do_wr = wr_en & (~full | rd_en);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_wr, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fft_pair_align.sv
// Re-aligns the skewed X and Y FFT bin streams into matched pairs for the cal
// block, numbering bins and flagging overflow and frame-boundary mismatches.
module fft_pair_align
    import fft_cal_pkg::*;
#(
    parameter int DW         = fft_cal_pkg::DW,
    parameter int NFFT       = fft_cal_pkg::NFFT,
    parameter int BIN_W      = fft_cal_pkg::BIN_W,
    parameter int FIFO_DEPTH = fft_cal_pkg::FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             xin_valid,
    input  logic [DW-1:0]    xin_re,
    input  logic [DW-1:0]    xin_im,
    input  logic             xin_last,
    input  logic             yin_valid,
    input  logic [DW-1:0]    yin_re,
    input  logic [DW-1:0]    yin_im,
    input  logic             yin_last,
    input  logic             clear_err,
    output logic [DW-1:0]    x_re,
    output logic [DW-1:0]    x_im,
    output logic [DW-1:0]    y_re,
    output logic [DW-1:0]    y_im,
    output logic             fft_out_valid,
    output logic [BIN_W-1:0] bin_idx,
    output logic             frame_end,
    output logic             err_ovf,
    output logic             err_last
);

    // Handshake: inputs are accepted whenever *_valid is high (no ready; a write to
    // a full FIFO is lost and flagged). fft_out_valid is a one-cycle strobe per pair.
    localparam int WW = 2 * DW + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [WW-1:0] x_dout, y_dout;
    logic          x_empty, y_empty, x_full, y_full;
    logic [CW-1:0] x_count, y_count;
    logic          pop, x_rd, y_rd, x_ovf, y_ovf;
    logic          xl, yl, both_last, bin_at_max, last_bad;

    logic [DW-1:0]    x_re_q, x_re_d, x_im_q, x_im_d;
    logic [DW-1:0]    y_re_q, y_re_d, y_im_q, y_im_d;
    logic             valid_q, valid_d;
    logic [BIN_W-1:0] bin_idx_q, bin_idx_d;
    logic [BIN_W-1:0] bin_cnt_q, bin_cnt_d;
    logic             frame_end_q, frame_end_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_last_q, err_last_d;

    sync_fifo #(.W(WW), .DEPTH(FIFO_DEPTH)) u_fifo_x (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (xin_valid),
        .din   ({xin_re, xin_im, xin_last}),
        .rd_en (x_rd),
        .dout  (x_dout),
        .empty (x_empty),
        .full  (x_full),
        .count (x_count)
    );

    sync_fifo #(.W(WW), .DEPTH(FIFO_DEPTH)) u_fifo_y (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (yin_valid),
        .din   ({yin_re, yin_im, yin_last}),
        .rd_en (y_rd),
        .dout  (y_dout),
        .empty (y_empty),
        .full  (y_full),
        .count (y_count)
    );

    assign pop   = (x_count != '0) & (y_count != '0);
    assign x_rd  = pop & ~x_empty;
    assign y_rd  = pop & ~y_empty;
    assign x_ovf = xin_valid & x_full & ~x_rd;
    assign y_ovf = yin_valid & y_full & ~y_rd;

    assign xl         = x_dout[0];
    assign yl         = y_dout[0];
    assign both_last  = xl & yl;
    assign bin_at_max = (bin_cnt_q == BIN_W'(NFFT - 1));
    assign last_bad   = (xl != yl) | (bin_at_max & ~both_last) | (both_last & ~bin_at_max);

    always_comb begin
        x_re_d      = x_re_q;
        x_im_d      = x_im_q;
        y_re_d      = y_re_q;
        y_im_d      = y_im_q;
        bin_idx_d   = bin_idx_q;
        bin_cnt_d   = bin_cnt_q;
        valid_d     = pop;
        frame_end_d = pop & both_last;
        if (pop) begin
            x_re_d    = x_dout[WW-1 -: DW];
            x_im_d    = x_dout[DW -: DW];
            y_re_d    = y_dout[WW-1 -: DW];
            y_im_d    = y_dout[DW -: DW];
            bin_idx_d = bin_cnt_q;
            // Any last bit resynchronises numbering so the next pair starts a frame.
            if (xl | yl || bin_at_max) bin_cnt_d = '0;
            else                       bin_cnt_d = bin_cnt_q + 1'b1;
        end
        if (x_ovf | y_ovf)  err_ovf_d = 1'b1;
        else if (clear_err) err_ovf_d = 1'b0;
        else                err_ovf_d = err_ovf_q;
        if (pop & last_bad) err_last_d = 1'b1;
        else if (clear_err) err_last_d = 1'b0;
        else                err_last_d = err_last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_re_q      <= '0;
            x_im_q      <= '0;
            y_re_q      <= '0;
            y_im_q      <= '0;
            valid_q     <= 1'b0;
            bin_idx_q   <= '0;
            bin_cnt_q   <= '0;
            frame_end_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_last_q  <= 1'b0;
        end else begin
            x_re_q      <= x_re_d;
            x_im_q      <= x_im_d;
            y_re_q      <= y_re_d;
            y_im_q      <= y_im_d;
            valid_q     <= valid_d;
            bin_idx_q   <= bin_idx_d;
            bin_cnt_q   <= bin_cnt_d;
            frame_end_q <= frame_end_d;
            err_ovf_q   <= err_ovf_d;
            err_last_q  <= err_last_d;
        end
    end

    assign x_re          = x_re_q;
    assign x_im          = x_im_q;
    assign y_re          = y_re_q;
    assign y_im          = y_im_q;
    assign fft_out_valid = valid_q;
    assign bin_idx       = bin_idx_q;
    assign frame_end     = frame_end_q;
    assign err_ovf       = err_ovf_q;
    assign err_last      = err_last_q;

endmodule
